// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encodings,
// default frame width and the owner-index width helper.
package uart_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    localparam int N_DEFAULT = 8;

    typedef enum logic [1:0] {
        S_IDLE      = ST_IDLE,
        S_ISSUE     = ST_ISSUE,
        S_WAIT_DONE = ST_WAIT_DONE
    } arb_state_t;

    // A single requester still needs a 1-bit index
    function automatic int owner_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester-side and transmitter-side signal bundle of uart_tx_arb.
// The timeout strobe exists only when UART_TX_ARB_TIMEOUT_EN is defined.
interface uart_tx_arb_if
    import uart_pkg::*;
#(
    parameter int N    = N_DEFAULT,
    parameter int NREQ = 4
);
    localparam int OW = owner_width(NREQ);

    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] req_data;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   done;
    logic [N-1:0]      tx_data;
    logic              tx_dv;
    logic              tx_ready;
    logic              tx_done;
    logic              busy;
    logic [OW-1:0]     owner;
`ifdef UART_TX_ARB_TIMEOUT_EN
    logic              timeout;
`endif

    modport master (
        input  req, req_data, tx_ready, tx_done,
        output ack, done, tx_data, tx_dv, busy, owner
`ifdef UART_TX_ARB_TIMEOUT_EN
        , output timeout
`endif
    );

    modport slave (
        output req, req_data, tx_ready, tx_done,
        input  ack, done, tx_data, tx_dv, busy, owner
`ifdef UART_TX_ARB_TIMEOUT_EN
        , input timeout
`endif
    );

endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward
// from ptr+1, wrapping modulo NREQ.
module rr_pick
    import uart_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = owner_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [W-1:0]    ptr,
    output logic            valid,
    output logic [W-1:0]    index
);

    logic [W-1:0] cand_s;

    // Scan from farthest to nearest offset so the nearest hit is the last write
    always_comb begin
        valid  = 1'b0;
        index  = {W{1'b0}};
        cand_s = {W{1'b0}};
        for (int off = NREQ; off >= 1; off--) begin
            cand_s = W'((int'(ptr) + off) % NREQ);
            valid  = valid | req[cand_s];
            index  = req[cand_s] ? cand_s : index;
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter between NREQ requesters.
// Define UART_TX_ARB_TIMEOUT_EN to abort WAIT_DONE after TIMEOUT_CYC clocks.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N           = N_DEFAULT,
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic           i_clk,
    input  logic           rst,
    uart_tx_arb_if.master  bus
);

    localparam int OW = owner_width(NREQ);
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    arb_state_t      state_r, state_nxt_s;
    logic [OW-1:0]   rr_ptr_r, rr_ptr_nxt_s;
    logic [OW-1:0]   owner_r, owner_nxt_s;
    logic [N-1:0]    tx_data_r, tx_data_nxt_s;
    logic            tx_dv_r, tx_dv_nxt_s;
    logic [NREQ-1:0] ack_r, ack_nxt_s;
    logic [NREQ-1:0] done_r, done_nxt_s;
    logic            busy_r;
    logic            win_valid_s;
    logic [OW-1:0]   win_idx_s;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             timeout_r, timeout_nxt_s;
`endif

    rr_pick #(.NREQ(NREQ), .W(OW)) u_pick (
        .req   (bus.req),
        .ptr   (rr_ptr_r),
        .valid (win_valid_s),
        .index (win_idx_s)
    );

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        state_nxt_s   = state_r;
        rr_ptr_nxt_s  = rr_ptr_r;
        owner_nxt_s   = owner_r;
        tx_data_nxt_s = tx_data_r;
        tx_dv_nxt_s   = 1'b0;
        ack_nxt_s     = {NREQ{1'b0}};
        done_nxt_s    = {NREQ{1'b0}};
`ifdef UART_TX_ARB_TIMEOUT_EN
        cnt_nxt_s     = cnt_r;
        timeout_nxt_s = 1'b0;
`endif
        case (state_r)
            S_IDLE: begin
                if (bus.tx_ready && win_valid_s) begin
                    owner_nxt_s   = win_idx_s;
                    tx_data_nxt_s = bus.req_data[int'(win_idx_s)*N +: N];
                    tx_dv_nxt_s   = 1'b1;
                    ack_nxt_s     = ONE_HOT0 << win_idx_s;
                    state_nxt_s   = S_ISSUE;
                end else begin
                    state_nxt_s   = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_nxt_s = S_WAIT_DONE;
`ifdef UART_TX_ARB_TIMEOUT_EN
                cnt_nxt_s   = {CNT_W{1'b0}};
`endif
            end
            S_WAIT_DONE: begin
                if (bus.tx_done) begin
                    done_nxt_s   = ONE_HOT0 << owner_r;
                    rr_ptr_nxt_s = owner_r;
                    state_nxt_s  = S_IDLE;
                end else begin
`ifdef UART_TX_ARB_TIMEOUT_EN
                    if (cnt_r == CNT_LAST) begin
                        timeout_nxt_s = 1'b1;
                        rr_ptr_nxt_s  = owner_r;
                        state_nxt_s   = S_IDLE;
                    end else begin
                        cnt_nxt_s     = cnt_r + CNT_W'(1);
                    end
`else
                    state_nxt_s = S_WAIT_DONE;
`endif
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State and registered-output update
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            rr_ptr_r  <= OW'(NREQ - 1);
            owner_r   <= {OW{1'b0}};
            tx_data_r <= {N{1'b0}};
            tx_dv_r   <= 1'b0;
            ack_r     <= {NREQ{1'b0}};
            done_r    <= {NREQ{1'b0}};
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            rr_ptr_r  <= rr_ptr_nxt_s;
            owner_r   <= owner_nxt_s;
            tx_data_r <= tx_data_nxt_s;
            tx_dv_r   <= tx_dv_nxt_s;
            ack_r     <= ack_nxt_s;
            done_r    <= done_nxt_s;
            busy_r    <= (state_nxt_s != S_IDLE);
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    // WAIT_DONE watchdog counter and abort strobe
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= {CNT_W{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            timeout_r <= timeout_nxt_s;
        end
    end

    assign bus.timeout = timeout_r;
`endif

    assign bus.ack     = ack_r;
    assign bus.done    = done_r;
    assign bus.tx_data = tx_data_r;
    assign bus.tx_dv   = tx_dv_r;
    assign bus.busy    = busy_r;
    assign bus.owner   = owner_r;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed self-checking bench for uart_tx_arb (NREQ=4, N=8); the timeout
// scenario runs when UART_TX_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arb;

    logic i_clk = 1'b0;
    logic rst   = 1'b1;
    int   total_cnt = 0;
    int   pass_cnt  = 0;
    int   cnt_a;
    int   cnt_b;
    int   order [6] = '{0, 1, 2, 3, 0, 1};

    uart_tx_arb_if #(.N(8), .NREQ(4)) u_if ();

    uart_tx_arb #(.N(8), .NREQ(4), .TIMEOUT_CYC(16)) u_dut (
        .i_clk (i_clk),
        .rst   (rst),
        .bus   (u_if)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic pulse_done();
        u_if.tx_done = 1'b1;
        tick();
        u_if.tx_done = 1'b0;
    endtask

    task automatic wait_dv(input string tag, input int limit);
        int seen;
        seen = 0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (u_if.tx_dv === 1'b1) begin
                seen = 1;
                break;
            end
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        u_if.req      = 4'b0000;
        u_if.req_data = 32'h0000_0000;
        u_if.tx_ready = 1'b1;
        u_if.tx_done  = 1'b0;
        tick();
        tick();
        chk("rst_ack",     32'(u_if.ack),     32'h0);
        chk("rst_done",    32'(u_if.done),    32'h0);
        chk("rst_dv",      32'(u_if.tx_dv),   32'h0);
        chk("rst_busy",    32'(u_if.busy),    32'h0);
        chk("rst_data",    32'(u_if.tx_data), 32'h0);
        chk("rst_owner",   32'(u_if.owner),   32'h0);

        // single request from requester 1
        rst = 1'b0;
        u_if.req = 4'b0010;
        u_if.req_data[15:8] = 8'hA5;
        tick();
        chk("single_ack",   32'(u_if.ack),     32'h2);
        chk("single_dv",    32'(u_if.tx_dv),   32'h1);
        chk("single_data",  32'(u_if.tx_data), 32'hA5);
        chk("single_owner", 32'(u_if.owner),   32'h1);
        chk("single_busy",  32'(u_if.busy),    32'h1);
        u_if.req = 4'b0000;
        tick();
        chk("single_dv_low", 32'(u_if.tx_dv), 32'h0);
        chk("single_ack_low", 32'(u_if.ack),  32'h0);
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            cnt_a += (u_if.done != 4'b0000) ? 1 : 0;
            cnt_b += (u_if.busy == 1'b1) ? 1 : 0;
        end
        chk("wait_no_done", 32'(cnt_a), 32'd0);
        chk("wait_busy",    32'(cnt_b), 32'd100);
        pulse_done();
        chk("single_done",  32'(u_if.done), 32'h2);
        chk("single_idle",  32'(u_if.busy), 32'h0);
        tick();
        chk("done_1cyc",    32'(u_if.done), 32'h0);
        pulse_done();
        tick();
        chk("idle_done_ign", 32'(u_if.done), 32'h0);
        chk("idle_dv_ign",   32'(u_if.tx_dv), 32'h0);

        // contention, fresh priority pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        u_if.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        u_if.req = 4'b1111;
        for (int f = 0; f < 6; f++) begin
            wait_dv("cont_dv_wait", 10);
            chk("cont_owner", 32'(u_if.owner),   32'(order[f]));
            chk("cont_data",  32'(u_if.tx_data), 32'h10 + 32'(order[f]));
            chk("cont_ack",   32'(u_if.ack),     32'h1 << order[f]);
            if (f == 5) u_if.req = 4'b0000;
            cnt_a = 0;
            cnt_b = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                cnt_a += u_if.tx_dv ? 1 : 0;
                cnt_b += (u_if.ack != 4'b0000) ? 1 : 0;
            end
            chk("cont_extra_dv",  32'(cnt_a), 32'd0);
            chk("cont_extra_ack", 32'(cnt_b), 32'd0);
            pulse_done();
            chk("cont_done", 32'(u_if.done), 32'h1 << order[f]);
        end

        // transmitter not ready
        tick();
        u_if.tx_ready = 1'b0;
        u_if.req = 4'b0001;
        cnt_a = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            cnt_a += u_if.tx_dv ? 1 : 0;
        end
        chk("nrdy_no_dv", 32'(cnt_a), 32'd0);
        chk("nrdy_idle",  32'(u_if.busy), 32'h0);
        u_if.tx_ready = 1'b1;
        tick();
        chk("nrdy_dv",    32'(u_if.tx_dv), 32'h1);
        chk("nrdy_owner", 32'(u_if.owner), 32'h0);
        u_if.req = 4'b0000;
        tick();
        tick();
        pulse_done();
        chk("nrdy_done", 32'(u_if.done), 32'h1);

        // data captured at grant edge
        u_if.req = 4'b0100;
        u_if.req_data[23:16] = 8'h3C;
        tick();
        chk("cap_ack",  32'(u_if.ack),     32'h4);
        chk("cap_data", 32'(u_if.tx_data), 32'h3C);
        u_if.req_data[23:16] = 8'hFF;
        u_if.req = 4'b0000;
        tick();
        chk("cap_hold", 32'(u_if.tx_data), 32'h3C);
        pulse_done();
        chk("cap_done", 32'(u_if.done), 32'h4);
        tick();
        chk("cap_hold_idle", 32'(u_if.tx_data), 32'h3C);

        // reset while owner 3 waits for completion
        u_if.req = 4'b1000;
        tick();
        chk("rmid_owner", 32'(u_if.owner), 32'h3);
        u_if.req = 4'b0000;
        tick();
        rst = 1'b1;
        #1;
        chk("rmid_busy",  32'(u_if.busy),    32'h0);
        chk("rmid_owner0", 32'(u_if.owner),  32'h0);
        chk("rmid_data",  32'(u_if.tx_data), 32'h0);
        chk("rmid_dv",    32'(u_if.tx_dv),   32'h0);
        chk("rmid_ack",   32'(u_if.ack),     32'h0);
        tick();
        rst = 1'b0;
        pulse_done();
        chk("rmid_no_done", 32'(u_if.done), 32'h0);
        u_if.req = 4'b1001;
        tick();
        chk("rmid_first_ack", 32'(u_if.ack),   32'h1);
        chk("rmid_first_own", 32'(u_if.owner), 32'h0);
        u_if.req = 4'b1000;

`ifdef UART_TX_ARB_TIMEOUT_EN
        cnt_a = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            cnt_a += u_if.timeout ? 1 : 0;
        end
        chk("to_early",   32'(cnt_a), 32'd0);
        chk("to_busy",    32'(u_if.busy), 32'h1);
        tick();
        chk("to_pulse",   32'(u_if.timeout), 32'h1);
        chk("to_idle",    32'(u_if.busy),    32'h0);
        chk("to_no_done", 32'(u_if.done),    32'h0);
        tick();
        chk("to_next_ack", 32'(u_if.ack),    32'h8);
        chk("to_next_own", 32'(u_if.owner),  32'h3);
        chk("to_1cyc",    32'(u_if.timeout), 32'h0);
`else
        tick();
        tick();
        pulse_done();
        chk("r0_done",    32'(u_if.done), 32'h1);
        tick();
        chk("next_ack",   32'(u_if.ack),   32'h8);
        chk("next_own",   32'(u_if.owner), 32'h3);
`endif
        u_if.req = 4'b0000;
        tick();
        tick();
        pulse_done();
        chk("last_done", 32'(u_if.done), 32'h8);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin arbiter and sequencer that shares one serial transmitter between NREQ byte-producing requesters.
- Selects a requester, captures its byte, and issues a one-cycle data-valid strobe to the transmitter.
- Holds ownership until the transmitter reports completion, then reports completion to the owner.
- Sits between the system-side producers (command responder, debug printer, etc.) and the transmitter's i_data/dv/tx_ready/tx_done interface.

Parameters:
- N, 8, data bits per frame; must match the transmitter.
- NREQ, 4, number of requesters, 2..16.
- TIMEOUT_CYC, 65536, clocks allowed in WAIT_DONE before abort; used only with the optional feature.

Ports:
- i_clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NREQ  per-requester request; level, held until ack.
- req_data  in  NREQ*N  packed bytes; requester k occupies bits [k*N +: N].
- ack  out  NREQ  one-hot, 1-cycle pulse; byte captured.
- done  out  NREQ  one-hot, 1-cycle pulse; owner's frame fully sent.
- tx_data  out  N  byte to transmitter i_data.
- tx_dv  out  1  1-cycle strobe to transmitter dv.
- tx_ready  in  1  transmitter idle.
- tx_done  in  1  transmitter 1-cycle completion pulse.
- busy  out  1  high whenever state != IDLE.
- owner  out  $clog2(NREQ)  index of current or last owner.

Behaviour:
- Reset values:
  - ack, done, tx_dv, busy = 0.
  - tx_data = 0, owner = 0.
  - rr_ptr = NREQ-1, so requester 0 has highest priority first.
  - state = IDLE.
- Reset mid-transfer: all of the above are forced immediately; no done pulse is produced for the aborted owner.
- States are IDLE, ISSUE, WAIT_DONE.
- IDLE:
  - If tx_ready=1 and |req, the winner is the first set req bit searching upward from rr_ptr+1, modulo NREQ.
  - At that edge: owner<=winner, tx_data<=req_data[winner], state<=ISSUE.
  - If tx_ready=0, no grant is made.
- ISSUE (exactly 1 cycle):
  - tx_dv=1 and ack[owner]=1 in the same cycle; state<=WAIT_DONE.
  - Latency: req sampled at edge E; tx_dv/ack high in the cycle after E.
- WAIT_DONE:
  - tx_ready is ignored.
  - On tx_done=1: done[owner] pulses in the next cycle, rr_ptr<=owner, state<=IDLE.
  - A new grant is possible on the first IDLE cycle, so there is a 1-cycle gap minimum between done and the next ack.
- Requester rules:
  - Data is captured at the grant edge; later changes to req/req_data are ignored.
  - A requester keeping req high after ack is treated as a new request and competes again.
  - Fairness: a continuously requesting agent waits at most NREQ-1 frames.
- A tx_done pulse in IDLE or ISSUE is ignored; it is not counted.
- tx_data holds its value after ISSUE until the next grant.
- busy/owner are registered, with no combinational path from req.
- The winner search is combinational from registered rr_ptr and live req; all outputs are registered.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- When defined:
  - A counter of width $clog2(TIMEOUT_CYC+1) clears on entering WAIT_DONE and increments each cycle in it.
  - When it reaches TIMEOUT_CYC with no tx_done, state<=IDLE, rr_ptr<=owner, and a 1-cycle output pulse timeout=1 is produced.
  - No done pulse is produced for that owner.
  - timeout resets to 0.
- When not defined:
  - The timeout port and counter are absent.
  - WAIT_DONE waits indefinitely.

Decomposition:
- Package uart_pkg holds:
  - State localparams ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_WAIT_DONE=2'd2.
  - Shared N default.
  - Helper function for owner width.
- Sub-module rr_pick (combinational): inputs req and ptr, outputs valid and index. It is reusable by other shared-resource arbiters.

Test Plan:
- Single request: req=0010, req_data[1]=8'hA5, tx_ready=1.
  - ack=0010 and tx_dv=1 with tx_data=8'hA5, 2 cycles after req rises.
  - Inject tx_done 100 cycles later → done=0010 the next cycle; busy falls.
- Contention: req=1111 held with fixed bytes 8'h10..8'h13; model returns tx_done 20 cycles after dv.
  - Grant order 0,1,2,3,0,1.
  - Exactly one ack per frame; no two tx_dv pulses without an intervening tx_done.
- Not ready: tx_ready=0, req=0001 → no tx_dv for 50 cycles; tx_ready→1 → tx_dv 2 cycles later.
- Data capture: req_data[2] changes 8'h3C→8'hFF the cycle after the grant edge → transmitted byte is 8'h3C.
- Reset mid-frame: assert rst while in WAIT_DONE (owner=3).
  - All outputs 0 immediately; no done pulse.
  - After release with req=1001, requester 0 wins first.
- Timeout (UART_TX_ARB_TIMEOUT_EN, TIMEOUT_CYC=16), with tx_done never asserted:
  - timeout pulses 16 cycles after entry to WAIT_DONE.
  - busy falls; the next pending requester is granted.
